// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: arbitrates NCH requesters onto a byte-serial single-port RAM bus
// with fixed or round-robin priority, per-channel read flush and a global rdy stall.
module mem_arbiter_nch #(
  parameter int NCH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LW = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1,
  parameter bit PRIO_RR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_we,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*LW-1:0]     req_len,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  input  logic [NCH-1:0]        req_flush,
  output logic [NCH-1:0]        resp_done,
  output logic [DATA_W-1:0]     resp_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_W-1:0]     mem_a,
  output logic                  mem_wr
);
  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 2);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, n;
  logic [GW-1:0] g, g_n, ptr, ptr_n, pick, idx;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [LW-1:0] len, len_n, rl;
  logic [DATA_W-1:0] wdata, wdata_n, cap, cap_n;
  logic [NCH-1:0] elig;
  logic act, fin, flush, fire, live;
  assign live = !rst;
  assign elig = req_valid & ~req_flush;
  assign n = CW'(len) + CW'(1);
  assign act = state != IDLE && cnt < n;
  assign fin = (state == READ) ? cnt == n + CW'(1) : (state == WRITE && cnt == n);
  assign flush = state == READ && req_flush[g];
  assign fire = rdy && live && fin && !flush;
  assign rl = req_len[pick*LW +: LW];
  assign mem_a = (act && live) ? addr + ADDR_W'(cnt) : '0;
  assign mem_wr = act && live && rdy && state == WRITE;
  assign mem_dout = (act && live && state == WRITE) ? 8'(wdata >> {cnt, 3'b000}) : 8'h00;
  assign resp_done = fire ? (NCH'(1) << g) : '0;
  assign resp_rdata = fire ? cap : '0;
  // Round-robin searches upward from ptr+1; the smallest offset wins, so iterate largest first.
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = PRIO_RR ? GW'((int'(ptr) + i) % NCH) : GW'(i - 1);
      if (elig[idx]) pick = idx;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    g_n = g;
    ptr_n = ptr;
    addr_n = addr;
    len_n = len;
    wdata_n = wdata;
    cap_n = cap;
    if (state == IDLE) begin
      cnt_n = '0;
      if (|elig) begin
        state_n = req_we[pick] ? WRITE : READ;
        g_n = pick;
        ptr_n = pick;
        addr_n = req_addr[pick*ADDR_W +: ADDR_W];
        len_n = (int'(rl) > NB - 1) ? LW'(NB - 1) : rl;
        wdata_n = req_wdata[pick*DATA_W +: DATA_W];
        cap_n = '0;
      end
    end else if (flush || fin) begin
      state_n = IDLE;
      cnt_n = '0;
      cap_n = flush ? '0 : cap;
    end else if (state == READ) begin
      for (int b = 0; b < NB; b++) if (int'(cnt) == b + 1) cap_n[8*b +: 8] = mem_din;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= GW'(NCH - 1);
      cap <= '0;
      g <= '0;
      addr <= '0;
      len <= '0;
      wdata <= '0;
    end else if (rdy) begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      cap <= cap_n;
      g <= g_n;
      addr <= addr_n;
      len <= len_n;
      wdata <= wdata_n;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: scenario tasks plus randomized transactions checked against a
// phase-counting bus model and a byte-array memory image.
module tb_mem_arbiter_nch;
  localparam int NCH = 2, AW = 32, DW = 32, LW = 2;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0;
  logic [NCH-1:0] req_valid = '0, req_we = '0, req_flush = '0;
  logic [NCH*AW-1:0] req_addr = '0;
  logic [NCH*LW-1:0] req_len = '0;
  logic [NCH*DW-1:0] req_wdata = '0;
  logic [NCH-1:0] resp_done, rr_done;
  logic [DW-1:0] resp_rdata, rr_rdata;
  logic [7:0] mem_din, mem_dout, rr_dout;
  logic [AW-1:0] mem_a, rr_a;
  logic mem_wr, rr_wr;
  logic pl_en = 1'b0;
  logic [9:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  logic [31:0] la [64];
  logic lwr [64];
  logic [7:0] ld [64];
  logic [1:0] ldn [64];
  logic [1:0] lrr [64];
  logic [31:0] lrd [64];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_nch #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .LW(LW), .PRIO_RR(1'b0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_flush(req_flush),
    .resp_done(resp_done), .resp_rdata(resp_rdata), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr));

  mem_arbiter_nch #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .LW(LW), .PRIO_RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_flush(req_flush),
    .resp_done(rr_done), .resp_rdata(rr_rdata), .mem_din(8'h00), .mem_dout(rr_dout),
    .mem_a(rr_a), .mem_wr(rr_wr));

  // RAM is stalled by the same rdy; read data lands one cycle after the address.
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    else if (pl_en) ram[pl_a] <= pl_d;
    else if (rdy && mem_wr) ram[mem_a[9:0]] <= mem_dout;
    if (rdy) mem_din <= ram[mem_a[9:0]];
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pl_a = a[9:0];
    pl_d = d;
    pl_en = 1'b1;
    ref_mem[a[9:0]] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic commit(input logic [31:0] a, input int len, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i <= len; i++) begin
      t = a + 32'(i);
      ref_mem[t[9:0]] = wd[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input int len);
    logic [31:0] v = '0, t;
    for (int i = 0; i <= len; i++) begin
      t = a + 32'(i);
      v[8*i +: 8] = ref_mem[t[9:0]];
    end
    return v;
  endfunction

  // Cycle k=0 presents the request; every rdy-high cycle advances the phase by one.
  // Bytes go out at phases 1..n, done at n+1 (write) or n+2 (read).
  function automatic logic [42:0] model(input int k, input int ch, input bit we, input logic [31:0] a,
                                        input int len, input logic [31:0] wd, input int st_at, input int st_n);
    int p = 0, n = len + 1;
    bit r, ewr = 1'b0;
    logic [31:0] ea = '0;
    logic [7:0] ed = '0;
    logic [1:0] edn;
    r = !(k >= st_at && k < st_at + st_n);
    for (int j = 0; j < k; j++) if (!(j >= st_at && j < st_at + st_n)) p++;
    if (p >= 1 && p <= n) begin
      ea = a + 32'(p - 1);
      ewr = we && r;
      ed = we ? wd[8*(p-1) +: 8] : 8'h00;
    end
    edn = (r && p == (we ? n + 1 : n + 2)) ? 2'(1 << ch) : 2'b00;
    return {ea, ewr, ed, edn};
  endfunction

  task automatic run(input int ch, input bit we, input logic [31:0] a, input int len, input logic [31:0] wd,
                     input int ncyc, input int st_at, input int st_n, input int fl_at, input int rs_at,
                     input int oth, input logic [31:0] oa);
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_we[ch] = we;
    req_addr[ch*AW +: AW] = a;
    req_len[ch*LW +: LW] = 2'(len);
    req_wdata[ch*DW +: DW] = wd;
    if (oth >= 0) begin
      req_valid[oth] = 1'b1;
      req_we[oth] = 1'b0;
      req_addr[oth*AW +: AW] = oa;
      req_len[oth*LW +: LW] = 2'd0;
    end
    for (int k = 0; k < ncyc; k++) begin
      rdy = !(k >= st_at && k < st_at + st_n);
      req_flush = (k == fl_at) ? 2'(1 << ch) : 2'b00;
      rst = (k == rs_at);
      @(negedge clk);
      la[k] = mem_a;
      lwr[k] = mem_wr;
      ld[k] = mem_dout;
      ldn[k] = resp_done;
      lrd[k] = resp_rdata;
      @(posedge clk); #1;
      req_valid = req_valid & ~ldn[k];
      if (k == fl_at || k == rs_at) req_valid[ch] = 1'b0;
    end
    req_valid = '0;
    req_flush = '0;
    rdy = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp_done, resp_rdata, mem_a, mem_wr, mem_dout} !== 75'd0) begin
      errors++;
      $display("FAIL reset_fixed got done=%b rdata=%h a=%h wr=%b dout=%h required all zero", resp_done, resp_rdata, mem_a, mem_wr, mem_dout);
    end
    checks++;
    if ({rr_done, rr_rdata, rr_a, rr_wr, rr_dout} !== 75'd0) begin
      errors++;
      $display("FAIL reset_rr got done=%b rdata=%h a=%h wr=%b dout=%h required all zero", rr_done, rr_rdata, rr_a, rr_wr, rr_dout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp_done, resp_rdata, mem_a, mem_wr, mem_dout} !== 75'd0) begin
      errors++;
      $display("FAIL idle_outputs got done=%b a=%h wr=%b required all zero", resp_done, mem_a, mem_wr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    logic [42:0] e;
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    run(1, 1'b0, 32'h100, 3, 32'h0, 10, -100, 0, -1, -1, -1, 32'h0);
    for (int k = 0; k < 10; k++) begin
      e = model(k, 1, 1'b0, 32'h100, 3, 32'h0, -100, 0);
      checks++;
      if ({la[k], lwr[k], ld[k], ldn[k]} !== e) begin
        errors++;
        $display("FAIL single_read k=%0d got %h required %h", k, {la[k], lwr[k], ld[k], ldn[k]}, e);
      end
    end
    checks++;
    if (ldn[6] !== 2'b10 || lrd[6] !== 32'h4433_2211) begin
      errors++;
      $display("FAIL single_read_data got done=%b rdata=%h required done=10 rdata=44332211", ldn[6], lrd[6]);
    end
  endtask

  task automatic test_write_wrap();
    logic [42:0] e;
    poke(32'h0, 8'h77); poke(32'h1, 8'h99);
    run(0, 1'b1, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 7, -100, 0, -1, -1, -1, 32'h0);
    for (int k = 0; k < 7; k++) begin
      e = model(k, 0, 1'b1, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, -100, 0);
      checks++;
      if ({la[k], lwr[k], ld[k], ldn[k]} !== e) begin
        errors++;
        $display("FAIL write_wrap k=%0d got %h required %h", k, {la[k], lwr[k], ld[k], ldn[k]}, e);
      end
    end
    checks++;
    if ({la[1], ld[1], la[2], ld[2], ldn[3]} !== {32'hFFFF_FFFF, 8'hEF, 32'h0, 8'hBE, 2'b01}) begin
      errors++;
      $display("FAIL write_wrap_bytes got %h/%h %h/%h done=%b required ffffffff/ef 00000000/be done=01", la[1], ld[1], la[2], ld[2], ldn[3]);
    end
    commit(32'hFFFF_FFFF, 1, 32'hDEAD_BEEF);
    run(0, 1'b0, 32'h0, 0, 32'h0, 6, -100, 0, -1, -1, -1, 32'h0);
    checks++;
    if (ldn[3] !== 2'b01 || lrd[3] !== 32'h0000_00BE) begin
      errors++;
      $display("FAIL zero_extend got done=%b rdata=%h required done=01 rdata=000000be", ldn[3], lrd[3]);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] ef, er;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_we = '0;
    req_len = '0;
    req_addr = {32'h20, 32'h10};
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ldn[k] = resp_done;
      lrr[k] = rr_done;
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int k = 0; k < 12; k++) begin
      ef = (k == 3 || k == 7 || k == 11) ? 2'b01 : 2'b00;
      er = (k == 3 || k == 11) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00;
      checks++;
      if (ldn[k] !== ef) begin
        errors++;
        $display("FAIL arb_fixed k=%0d got %b required %b", k, ldn[k], ef);
      end
      checks++;
      if (lrr[k] !== er) begin
        errors++;
        $display("FAIL arb_rr k=%0d got %b required %b", k, lrr[k], er);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_read();
    logic [1:0] e;
    poke(32'h40, 8'h5A);
    run(0, 1'b0, 32'h200, 3, 32'h0, 12, -100, 0, 3, -1, 1, 32'h40);
    for (int k = 0; k < 12; k++) begin
      e = (k == 7) ? 2'b10 : 2'b00;
      checks++;
      if (ldn[k] !== e) begin
        errors++;
        $display("FAIL flush_done k=%0d got %b required %b", k, ldn[k], e);
      end
    end
    checks++;
    if ({la[1], la[3], la[4], la[5], lrd[7]} !== {32'h200, 32'h202, 32'h0, 32'h40, 32'h5A}) begin
      errors++;
      $display("FAIL flush_bus got a1=%h a3=%h a4=%h a5=%h rdata=%h required 200 202 0 40 5a", la[1], la[3], la[4], la[5], lrd[7]);
    end
  endtask

  task automatic test_flush_write();
    logic [42:0] e;
    logic [31:0] wd;
    wd = $urandom;
    run(0, 1'b1, 32'h300, 3, wd, 9, -100, 0, 3, -1, -1, 32'h0);
    for (int k = 0; k < 9; k++) begin
      e = model(k, 0, 1'b1, 32'h300, 3, wd, -100, 0);
      checks++;
      if ({la[k], lwr[k], ld[k], ldn[k]} !== e) begin
        errors++;
        $display("FAIL flush_write k=%0d got %h required %h", k, {la[k], lwr[k], ld[k], ldn[k]}, e);
      end
    end
    commit(32'h300, 3, wd);
    run(0, 1'b0, 32'h300, 3, 32'h0, 9, -100, 0, -1, -1, -1, 32'h0);
    checks++;
    if (lrd[6] !== wd) begin
      errors++;
      $display("FAIL flush_write_readback got %h required %h", lrd[6], wd);
    end
  endtask

  task automatic test_stall();
    logic [42:0] e;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) poke(32'h180 + 32'(i), 8'($urandom));
    v = exp_rd(32'h180, 3);
    run(1, 1'b0, 32'h180, 3, 32'h0, 13, 2, 3, -1, -1, -1, 32'h0);
    for (int k = 0; k < 13; k++) begin
      e = model(k, 1, 1'b0, 32'h180, 3, 32'h0, 2, 3);
      checks++;
      if ({la[k], lwr[k], ld[k], ldn[k]} !== e) begin
        errors++;
        $display("FAIL stall k=%0d got %h required %h", k, {la[k], lwr[k], ld[k], ldn[k]}, e);
      end
    end
    checks++;
    if (ldn[9] !== 2'b10 || lrd[9] !== v) begin
      errors++;
      $display("FAIL stall_data got done=%b rdata=%h required done=10 rdata=%h", ldn[9], lrd[9], v);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    run(0, 1'b0, 32'h100, 3, 32'h0, 10, -100, 0, -1, 3, -1, 32'h0);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (ldn[k] !== 2'b00 || (k >= 4 && {la[k], lwr[k], ld[k], lrd[k]} !== 73'd0)) begin
        errors++;
        $display("FAIL reset_mid k=%0d got a=%h wr=%b d=%h done=%b rdata=%h required zero", k, la[k], lwr[k], ld[k], ldn[k], lrd[k]);
      end
    end
    v = exp_rd(32'h100, 3);
    run(0, 1'b0, 32'h100, 3, 32'h0, 9, -100, 0, -1, -1, -1, 32'h0);
    checks++;
    if (ldn[6] !== 2'b01 || lrd[6] !== v) begin
      errors++;
      $display("FAIL reset_mid_after got done=%b rdata=%h required done=01 rdata=%h", ldn[6], lrd[6], v);
    end
  endtask

  task automatic test_random();
    logic [42:0] e;
    logic [31:0] a, wd, v;
    int ch, len, st_at, st_n, nc;
    bit we;
    for (int t = 0; t < 24; t++) begin
      ch = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 3);
      a = {22'($urandom), 10'($urandom_range(0, 15))};
      wd = $urandom;
      st_at = -100;
      st_n = 0;
      if ($urandom_range(0, 1) == 1) begin
        st_at = $urandom_range(1, len + 3);
        st_n = $urandom_range(1, 3);
      end
      nc = len + st_n + 5;
      v = exp_rd(a, len);
      run(ch, we, a, len, wd, nc, st_at, st_n, -1, -1, -1, 32'h0);
      for (int k = 0; k < nc; k++) begin
        e = model(k, ch, we, a, len, wd, st_at, st_n);
        checks++;
        if ({la[k], lwr[k], ld[k], ldn[k]} !== e) begin
          errors++;
          $display("FAIL random t=%0d k=%0d got %h required %h", t, k, {la[k], lwr[k], ld[k], ldn[k]}, e);
        end
        if (!we && e[1:0] != 2'b00) begin
          checks++;
          if (lrd[k] !== v) begin
            errors++;
            $display("FAIL random_rdata t=%0d got %h required %h", t, lrd[k], v);
          end
        end
      end
      if (we) commit(a, len, wd);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_single_read();
    test_write_wrap();
    test_arbitration();
    test_flush_read();
    test_flush_write();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
